// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the memory stage. It handles byte,
//               half and word loads and stores with a fixed read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  RE,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [2:0]            funct3,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] LMD,
    output logic                  err,
    output logic                  stall
);

    localparam int                  c_addr_w    = $clog2(DEPTH_WORDS);
    localparam logic [DATA_WIDTH-1:0] c_depth   = DATA_WIDTH'(DEPTH_WORDS);
    localparam logic [3:0]          c_busy_init = 4'(READ_LATENCY - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [3:0]            r_cnt_q,   w_cnt_d;
    logic [DATA_WIDTH-1:0] r_lmd_q,   w_lmd_d;
    logic                  r_err_q,   w_err_d;
    logic [c_addr_w-1:0]   r_idx_q,   w_idx_d;
    logic [1:0]            r_off_q,   w_off_d;
    logic [2:0]            r_f3_q,    w_f3_d;

    logic [31:0]           r_mem [DEPTH_WORDS];

    logic                  w_accept;
    logic                  w_req_err;
    logic                  w_f3_ok;
    logic                  w_unsigned;
    logic                  w_half;
    logic                  w_word;
    logic                  w_out_of_range;
    logic [c_addr_w-1:0]   w_idx;
    logic                  w_wr_en;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [c_addr_w-1:0]   w_rd_idx;
    logic [1:0]            w_rd_off;
    logic [2:0]            w_rd_f3;
    logic [DATA_WIDTH-1:0] w_rd_data;

    function automatic logic [DATA_WIDTH-1:0] f_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [7:0]  v_b;
        logic [15:0] v_h;
        v_b = word[{off, 3'b000} +: 8];
        v_h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  f_extract = {{24{v_b[7]}}, v_b};
            3'b001:  f_extract = {{16{v_h[15]}}, v_h};
            3'b100:  f_extract = {24'd0, v_b};
            3'b101:  f_extract = {16'd0, v_h};
            default: f_extract = word;
        endcase
    endfunction

    assign req_ready  = (r_state_q == ST_IDLE) && !rst;
    assign w_accept   = req_ready && req_valid && (RE || WE);
    assign resp_valid = (r_state_q == ST_RESP);
    assign LMD        = r_lmd_q;
    assign err        = r_err_q;
    assign stall      = !rst && (((r_state_q == ST_IDLE) && req_valid && (RE || WE))
                                 || (r_state_q == ST_BUSY));

    assign w_f3_ok        = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010)
                         || (funct3 == 3'b100) || (funct3 == 3'b101);
    assign w_unsigned     = (funct3 == 3'b100) || (funct3 == 3'b101);
    assign w_half         = (funct3[1:0] == 2'b01);
    assign w_word         = (funct3[1:0] == 2'b10);
    assign w_out_of_range = ({2'b00, address[DATA_WIDTH-1:2]} >= c_depth);
    assign w_req_err      = (RE && WE) || !w_f3_ok || (w_unsigned && WE)
                         || (w_half && address[0]) || (w_word && (address[1:0] != 2'b00))
                         || w_out_of_range;
    assign w_idx          = address[c_addr_w+1:2];
    assign w_wr_en        = w_accept && !w_req_err && WE;

    // Byte-lane enables with the store data replicated across lanes.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = write_data[31:0];
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << address[1:0];
                w_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                w_be    = address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Single read port: live request while idle, captured request while busy.
    assign w_rd_idx  = (r_state_q == ST_IDLE) ? w_idx        : r_idx_q;
    assign w_rd_off  = (r_state_q == ST_IDLE) ? address[1:0] : r_off_q;
    assign w_rd_f3   = (r_state_q == ST_IDLE) ? funct3       : r_f3_q;
    assign w_rd_data = f_extract(r_mem[w_rd_idx], w_rd_off, w_rd_f3);

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_lmd_d   = r_lmd_q;
        w_err_d   = r_err_q;
        w_idx_d   = r_idx_q;
        w_off_d   = r_off_q;
        w_f3_d    = r_f3_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_idx_d = w_idx;
                    w_off_d = address[1:0];
                    w_f3_d  = funct3;
                    w_err_d = w_req_err;
                    if (w_req_err) begin
                        w_lmd_d   = '0;
                        w_state_d = ST_RESP;
                    end else if (WE) begin
                        w_state_d = ST_RESP;
                    end else if (READ_LATENCY == 1) begin
                        w_lmd_d   = w_rd_data;
                        w_state_d = ST_RESP;
                    end else begin
                        w_cnt_d   = c_busy_init;
                        w_state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt_q == 4'd0) begin
                    w_lmd_d   = w_rd_data;
                    w_state_d = ST_RESP;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            ST_RESP: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= 4'd0;
            r_lmd_q   <= '0;
            r_err_q   <= 1'b0;
            r_idx_q   <= '0;
            r_off_q   <= 2'd0;
            r_f3_q    <= 3'd0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_lmd_q   <= w_lmd_d;
            r_err_q   <= w_err_d;
            r_idx_q   <= w_idx_d;
            r_off_q   <= w_off_d;
            r_f3_q    <= w_f3_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        RE;
    logic        WE;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [2:0]  funct3;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] LMD;
    logic        err;
    logic        stall;
    logic        b_req_ready;
    logic        b_resp_valid;
    logic [31:0] b_LMD;
    logic        b_err;
    logic        b_stall;

    int n_total = 0;
    int n_bad   = 0;

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .RE(RE), .WE(WE),
        .address(address), .write_data(write_data), .funct3(funct3),
        .req_ready(req_ready), .resp_valid(resp_valid), .LMD(LMD),
        .err(err), .stall(stall)
    );

    dmem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(4)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .RE(RE), .WE(WE),
        .address(address), .write_data(write_data), .funct3(funct3),
        .req_ready(b_req_ready), .resp_valid(b_resp_valid), .LMD(b_LMD),
        .err(b_err), .stall(b_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        RE         = 1'b0;
        WE         = 1'b0;
        address    = 32'hFFFF_FFFF;
        write_data = 32'h0;
        funct3     = 3'b111;
    endtask

    // One request: accept, scramble inputs, wait for the response, return to idle.
    task automatic go(input string tag, input logic re, input logic we,
                      input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                      input int elat, input logic [31:0] ed, input logic ee);
        int          lat;
        logic        st_acc;
        logic        st_busy;
        logic        st_resp;
        req_valid  = 1'b1;
        RE         = re;
        WE         = we;
        address    = a;
        write_data = wd;
        funct3     = f3;
        #1;
        st_acc = stall;
        tick();
        idle_inputs();
        lat     = 1;
        st_busy = 1'b1;
        while (!resp_valid && lat < 20) begin
            st_busy = st_busy & stall;
            tick();
            lat++;
        end
        st_resp = stall;
        chk({tag, "_lat"},   32'(lat), 32'(elat));
        chk({tag, "_lmd"},   LMD, ed);
        chk({tag, "_err"},   32'(err), 32'(ee));
        chk({tag, "_stall"}, 32'({st_acc, st_busy, st_resp}), 32'b110);
        tick();
        chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic seen;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        req_valid = 1'b1;
        RE        = 1'b1;
        funct3    = 3'b010;
        address   = 32'h10;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        tick();
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("rst_rdy_after", 32'(req_ready), 32'd1);
        chk("rst_resp",      32'(resp_valid), 32'd0);
        chk("rst_lmd",       LMD, 32'h0);
        chk("rst_err",       32'(err), 32'd0);

        // A valid request with neither enable is ignored.
        req_valid = 1'b1;
        #1;
        chk("ign_stall", 32'(stall), 32'd0);
        tick();
        chk("ign_resp",  32'(resp_valid), 32'd0);
        chk("ign_ready", 32'(req_ready), 32'd1);
        idle_inputs();

        go("sw_beef",  1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, 3'b010, 1, 32'h0,         1'b0);
        go("lw_beef",  1'b1, 1'b0, 32'h10,  32'h0,         3'b010, 2, 32'hDEAD_BEEF, 1'b0);
        go("sw_80ff",  1'b0, 1'b1, 32'h10,  32'h80FF_0000, 3'b010, 1, 32'hDEAD_BEEF, 1'b0);
        go("lb_13",    1'b1, 1'b0, 32'h13,  32'h0,         3'b000, 2, 32'hFFFF_FF80, 1'b0);
        go("lbu_13",   1'b1, 1'b0, 32'h13,  32'h0,         3'b100, 2, 32'h0000_0080, 1'b0);
        go("lh_12",    1'b1, 1'b0, 32'h12,  32'h0,         3'b001, 2, 32'hFFFF_80FF, 1'b0);
        go("sw_20",    1'b0, 1'b1, 32'h20,  32'hDEAD_BEEF, 3'b010, 1, 32'hFFFF_80FF, 1'b0);
        go("sh_22",    1'b0, 1'b1, 32'h22,  32'h0000_1234, 3'b001, 1, 32'hFFFF_80FF, 1'b0);
        go("lw_20",    1'b1, 1'b0, 32'h20,  32'h0,         3'b010, 2, 32'h1234_BEEF, 1'b0);
        go("sb_21",    1'b0, 1'b1, 32'h21,  32'h0000_00A5, 3'b000, 1, 32'h1234_BEEF, 1'b0);
        go("lw_20b",   1'b1, 1'b0, 32'h20,  32'h0,         3'b010, 2, 32'h1234_A5EF, 1'b0);
        go("lhu_22",   1'b1, 1'b0, 32'h22,  32'h0,         3'b101, 2, 32'h0000_1234, 1'b0);
        go("lw_mis",   1'b1, 1'b0, 32'h11,  32'h0,         3'b010, 1, 32'h0,         1'b1);
        go("lw_10a",   1'b1, 1'b0, 32'h10,  32'h0,         3'b010, 2, 32'h80FF_0000, 1'b0);
        go("sw_mis",   1'b0, 1'b1, 32'h12,  32'h1111_1111, 3'b010, 1, 32'h0,         1'b1);
        go("lw_10b",   1'b1, 1'b0, 32'h10,  32'h0,         3'b010, 2, 32'h80FF_0000, 1'b0);
        go("re_we",    1'b1, 1'b1, 32'h10,  32'h2222_2222, 3'b010, 1, 32'h0,         1'b1);
        go("bad_f3",   1'b1, 1'b0, 32'h10,  32'h0,         3'b011, 1, 32'h0,         1'b1);
        go("sbu",      1'b0, 1'b1, 32'h10,  32'h3333_3333, 3'b100, 1, 32'h0,         1'b1);
        go("sw_top",   1'b0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 3'b010, 1, 32'h0,         1'b0);
        go("lw_top",   1'b1, 1'b0, 32'hFFC, 32'h0,         3'b010, 2, 32'hCAFE_F00D, 1'b0);
        go("lw_oor",   1'b1, 1'b0, 32'h1000, 32'h0,        3'b010, 1, 32'h0,         1'b1);
        go("lw_10c",   1'b1, 1'b0, 32'h10,  32'h0,         3'b010, 2, 32'h80FF_0000, 1'b0);
        go("sw_30",    1'b0, 1'b1, 32'h30,  32'h0102_0304, 3'b010, 1, 32'h80FF_0000, 1'b0);

        // Back-to-back stores with req_valid held high throughout.
        req_valid  = 1'b1;
        WE         = 1'b1;
        funct3     = 3'b010;
        address    = 32'h40;
        write_data = 32'hA1B2_C3D4;
        #1;
        chk("b2b_rdy0", 32'(req_ready), 32'd1);
        tick();
        chk("b2b_resp1", 32'({resp_valid, req_ready, stall}), 32'b100);
        address    = 32'h44;
        write_data = 32'h5566_7788;
        tick();
        chk("b2b_rdy2", 32'({resp_valid, req_ready}), 32'b01);
        tick();
        chk("b2b_resp2", 32'(resp_valid), 32'd1);
        idle_inputs();
        tick();
        go("b2b_lw40", 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 2, 32'hA1B2_C3D4, 1'b0);
        go("b2b_lw44", 1'b1, 1'b0, 32'h44, 32'h0, 3'b010, 2, 32'h5566_7788, 1'b0);

        // Reset pulsed during the first busy cycle of a latency-4 read.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("b_rst_state", 32'({b_req_ready, b_resp_valid, b_err, b_stall}), 32'b1000);
        chk("b_rst_lmd", b_LMD, 32'h0);
        req_valid = 1'b1;
        RE        = 1'b1;
        funct3    = 3'b010;
        address   = 32'h10;
        #1;
        tick();
        idle_inputs();
        #1;
        chk("b_busy_stall", 32'(b_stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("b_rdy_after", 32'(b_req_ready), 32'd1);
        seen = b_resp_valid;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | b_resp_valid;
        end
        chk("b_no_resp", 32'(seen), 32'd0);
        go("persist", 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 2, 32'hA1B2_C3D4, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
